// File: rtl/vector_regfile_pkg.sv
// rtl/vector_regfile_pkg.sv - shared types, sizes and byte-merge helper for the vector register file
package vector_regfile_pkg;

    localparam int VRF_W  = 16;
    localparam int VRF_L  = 32;
    localparam int VRF_NR = 4;
    localparam int VRF_NW = 2;
    localparam int VRF_BE = VRF_W / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // Ports are visited in ascending order so the highest-index enabled writer owns each byte.
    function automatic logic [VRF_W-1:0] merge_word(
        input logic [VRF_W-1:0]                  old_w,
        input logic [VRF_NW-1:0][VRF_W-1:0]      data,
        input logic [VRF_NW-1:0][VRF_BE-1:0]     be,
        input logic [VRF_NW-1:0]                 hit
    );
        logic [VRF_W-1:0] r;
        r = old_w;
        for (int p = 0; p < VRF_NW; p++) begin
            for (int b = 0; b < VRF_BE; b++) begin
                if (hit[p] && be[p][b]) begin
                    r[8*b +: 8] = data[p][8*b +: 8];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vrf_clear_ctrl.sv
// rtl/vrf_clear_ctrl.sv - bulk-clear sequencer: walks every entry once per accepted clr_req
module vrf_clear_ctrl
    import vector_regfile_pkg::*;
#(
    parameter int L = VRF_L,
    parameter int A = $clog2(L)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_req,
    output logic         clr_busy,
    output logic         clr_active,
    output logic [A-1:0] clr_idx
);

    clr_state_e   state_q, state_d;
    logic [A-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == A'(L - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign clr_active = (state_q == CLEAR);
    assign clr_busy   = clr_active;
    assign clr_idx    = cnt_q;

endmodule

// File: rtl/vector_regfile_v3.sv
// rtl/vector_regfile_v3.sv - multi-port vector register file with byte-merge writes, write-first reads and bulk clear
module vector_regfile_v3
    import vector_regfile_pkg::*;
#(
    parameter int W  = VRF_W,
    parameter int L  = VRF_L,
    parameter int NR = VRF_NR,
    parameter int NW = VRF_NW,
    parameter int A  = $clog2(L),
    parameter int BE = W / 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NR-1:0]          rd_en,
    input  logic [NR-1:0][A-1:0]   rd_addr,
    output logic [NR-1:0][W-1:0]   rd_data,
    output logic [NR-1:0]          rd_valid,
    input  logic [NW-1:0]          wr_en,
    input  logic [NW-1:0][A-1:0]   wr_addr,
    input  logic [NW-1:0][W-1:0]   wr_data,
    input  logic [NW-1:0][BE-1:0]  wr_be,
    input  logic                   clr_req,
    output logic                   clr_busy,
    output logic                   wr_conflict,
    output logic                   wr_drop
);

    localparam logic [A:0] L_LIM = (A + 1)'(L);

    logic               clr_active;
    logic [A-1:0]       clr_idx;

    logic [W-1:0]       mem_q [L];
    logic [W-1:0]       mem_d [L];
    logic [NR-1:0][W-1:0] rd_data_q, rd_data_d;
    logic [NR-1:0]      rd_valid_q, rd_valid_d;
    logic               conflict_q, conflict_d;
    logic               drop_q, drop_d;
    logic [NW-1:0]      wr_ok;
    logic [NW-1:0]      hit;

    vrf_clear_ctrl #(.L(L), .A(A)) u_clear_ctrl (
        .clk        (clk),
        .reset      (reset),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .clr_active (clr_active),
        .clr_idx    (clr_idx)
    );

    always_comb begin
        wr_ok      = '0;
        hit        = '0;
        drop_d     = 1'b0;
        conflict_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_en;

        for (int p = 0; p < NW; p++) begin
            wr_ok[p] = wr_en[p] && ({1'b0, wr_addr[p]} < L_LIM) && !clr_busy;
            if (wr_en[p] && !wr_ok[p]) begin
                drop_d = 1'b1;
            end
        end

        for (int p = 0; p < NW; p++) begin
            for (int q = p + 1; q < NW; q++) begin
                if (wr_ok[p] && wr_ok[q] && (wr_addr[p] == wr_addr[q]) && |(wr_be[p] & wr_be[q])) begin
                    conflict_d = 1'b1;
                end
            end
        end

        // Sweep zeroing overrides any merge so a same-cycle read of the swept entry sees 0.
        for (int e = 0; e < L; e++) begin
            for (int p = 0; p < NW; p++) begin
                hit[p] = wr_ok[p] && (wr_addr[p] == A'(e));
            end
            mem_d[e] = merge_word(mem_q[e], wr_data, wr_be, hit);
            if (clr_active && (clr_idx == A'(e))) begin
                mem_d[e] = '0;
            end
        end

        for (int r = 0; r < NR; r++) begin
            if (rd_en[r]) begin
                rd_data_d[r] = ({1'b0, rd_addr[r]} < L_LIM) ? mem_d[rd_addr[r]] : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < L; e++) begin
                mem_q[e] <= '0;
            end
            rd_data_q  <= '0;
            rd_valid_q <= '0;
            conflict_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            for (int e = 0; e < L; e++) begin
                mem_q[e] <= mem_d[e];
            end
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            conflict_q <= conflict_d;
            drop_q     <= drop_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign wr_conflict = conflict_q;
    assign wr_drop     = drop_q;

endmodule

// File: tb/tb_vector_regfile_v3.sv
// tb/tb_vector_regfile_v3.sv - self-checking bench for vector_regfile_v3 against a behavioural model
module tb_vector_regfile_v3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [3:0]        rd_en = '0;
    logic [3:0][4:0]   rd_addr = '0;
    logic [3:0][15:0]  rd_data;
    logic [3:0]        rd_valid;
    logic [1:0]        wr_en = '0;
    logic [1:0][4:0]   wr_addr = '0;
    logic [1:0][15:0]  wr_data = '0;
    logic [1:0][1:0]   wr_be = '0;
    logic              clr_req = 1'b0;
    logic              clr_busy;
    logic              wr_conflict;
    logic              wr_drop;

    int checks = 0;
    int failures = 0;

    // Model state
    logic [15:0] mmem [32];
    logic [15:0] exp_rd [4];
    logic [3:0]  exp_valid;
    logic        exp_conf;
    logic        exp_drop;
    int          clr_left;
    int          clr_ix;
    int          busy_cnt;

    vector_regfile_v3 dut (
        .clk         (clk),
        .reset       (reset),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_be       (wr_be),
        .clr_req     (clr_req),
        .clr_busy    (clr_busy),
        .wr_conflict (wr_conflict),
        .wr_drop     (wr_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int e = 0; e < 32; e++) mmem[e] = '0;
        for (int r = 0; r < 4; r++) exp_rd[r] = '0;
        exp_valid = '0;
        exp_conf  = 1'b0;
        exp_drop  = 1'b0;
        clr_left  = 0;
        clr_ix    = 0;
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must clear without a clock.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        model_reset();
        chk("reset_clr_busy", {31'd0, clr_busy}, 32'd0);
        chk("reset_rd_valid", {28'd0, rd_valid}, 32'd0);
        chk("reset_rd_data", {rd_data[1], rd_data[0]} | {rd_data[3], rd_data[2]}, 32'd0);
        chk("reset_flags", {30'd0, wr_conflict, wr_drop}, 32'd0);
        reset = 1'b0;
    endtask

    task automatic cycle();
        logic [15:0] nm [32];
        logic        busy;
        busy     = (clr_left > 0);
        exp_drop = 1'b0;
        exp_conf = 1'b0;
        for (int e = 0; e < 32; e++) nm[e] = mmem[e];
        for (int p = 0; p < 2; p++) begin
            if (wr_en[p]) begin
                if (busy) exp_drop = 1'b1;
                else begin
                    for (int b = 0; b < 2; b++)
                        if (wr_be[p][b]) nm[wr_addr[p]][8*b +: 8] = wr_data[p][8*b +: 8];
                end
            end
        end
        if (!busy && wr_en == 2'b11 && wr_addr[0] == wr_addr[1] && (wr_be[0] & wr_be[1]) != 2'b00)
            exp_conf = 1'b1;
        if (busy) begin
            nm[clr_ix] = '0;
            clr_ix++;
            clr_left--;
        end else if (clr_req) begin
            clr_left = 32;
            clr_ix   = 0;
        end
        for (int r = 0; r < 4; r++) begin
            exp_valid[r] = rd_en[r];
            if (rd_en[r]) exp_rd[r] = nm[rd_addr[r]];
        end
        for (int e = 0; e < 32; e++) mmem[e] = nm[e];

        @(posedge clk);
        #1;
        chk("clr_busy", {31'd0, clr_busy}, {31'd0, (clr_left > 0)});
        chk("wr_conflict", {31'd0, wr_conflict}, {31'd0, exp_conf});
        chk("wr_drop", {31'd0, wr_drop}, {31'd0, exp_drop});
        chk("rd_valid", {28'd0, rd_valid}, {28'd0, exp_valid});
        for (int r = 0; r < 4; r++) chk($sformatf("rd_data%0d", r), {16'd0, rd_data[r]}, {16'd0, exp_rd[r]});

        rd_en   = '0;
        wr_en   = '0;
        clr_req = 1'b0;
    endtask

    task automatic read_all();
        for (int i = 0; i < 8; i++) begin
            rd_en = 4'hF;
            for (int r = 0; r < 4; r++) rd_addr[r] = 5'(i * 4 + r);
            cycle();
        end
    endtask

    task automatic rand_cycle();
        wr_en      = 2'($urandom);
        wr_addr[0] = 5'($urandom_range(0, 31));
        wr_addr[1] = ($urandom_range(0, 2) == 0) ? wr_addr[0] : 5'($urandom_range(0, 31));
        wr_data[0] = 16'($urandom);
        wr_data[1] = 16'($urandom);
        wr_be[0]   = 2'($urandom);
        wr_be[1]   = 2'($urandom);
        rd_en      = 4'($urandom);
        for (int r = 0; r < 4; r++) rd_addr[r] = 5'($urandom_range(0, 31));
        clr_req    = ($urandom_range(0, 80) == 0);
        cycle();
    endtask

    task automatic fill_index_plus_one();
        for (int i = 0; i < 16; i++) begin
            wr_en = 2'b11;
            wr_be = '{2'b11, 2'b11};
            wr_addr[0] = 5'(2 * i);
            wr_addr[1] = 5'(2 * i + 1);
            wr_data[0] = 16'(2 * i + 1);
            wr_data[1] = 16'(2 * i + 2);
            cycle();
        end
    endtask

    initial begin
        model_reset();
        do_reset();

        // Random traffic, reset in the middle of it, then every entry must read 0
        for (int i = 0; i < 20; i++) rand_cycle();
        do_reset();
        read_all();

        // Overlapping writes: highest port wins, conflict flagged
        wr_en = 2'b11; wr_addr[0] = 5'd5; wr_addr[1] = 5'd5;
        wr_data[0] = 16'h1111; wr_data[1] = 16'h2222; wr_be = '{2'b11, 2'b11};
        cycle();
        chk("conflict_full_overlap", {31'd0, wr_conflict}, 32'd1);
        rd_en = 4'b0001; rd_addr[0] = 5'd5;
        cycle();
        chk("merge_full_overlap", {16'd0, rd_data[0]}, 32'h2222);

        // Disjoint bytes merge without conflict
        wr_en = 2'b11; wr_addr[0] = 5'd5; wr_addr[1] = 5'd5;
        wr_data[0] = 16'h1111; wr_data[1] = 16'h2222; wr_be[0] = 2'b01; wr_be[1] = 2'b10;
        cycle();
        chk("conflict_disjoint", {31'd0, wr_conflict}, 32'd0);
        rd_en = 4'b0001; rd_addr[0] = 5'd5;
        cycle();
        chk("merge_disjoint", {16'd0, rd_data[0]}, 32'h2211);

        // Write-first bypass on port 2, port 3 reads an untouched neighbour
        wr_en = 2'b01; wr_addr[0] = 5'd7; wr_data[0] = 16'hBEEF; wr_be[0] = 2'b11;
        rd_en = 4'b1100; rd_addr[2] = 5'd7; rd_addr[3] = 5'd8;
        cycle();
        chk("bypass_port2", {16'd0, rd_data[2]}, 32'hBEEF);
        chk("bypass_port3_other", {16'd0, rd_data[3]}, 32'h0000);

        // Bulk clear sweep
        fill_index_plus_one();
        clr_req = 1'b1;
        cycle();
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (clr_busy) busy_cnt++;
            if (i == 3) begin
                wr_en = 2'b01; wr_addr[0] = 5'd20; wr_data[0] = 16'hFFFF; wr_be[0] = 2'b11;
            end
            if (i == 5) begin
                rd_en = 4'b0001; rd_addr[0] = 5'd10;
            end
            if (i == 8) clr_req = 1'b1;
            cycle();
            if (i == 3) chk("drop_during_sweep", {31'd0, wr_drop}, 32'd1);
            if (i == 5) chk("read_before_zeroed", {16'd0, rd_data[0]}, 32'h000B);
        end
        chk("sweep_length", busy_cnt, 32);
        rd_en = 4'b0011; rd_addr[0] = 5'd10; rd_addr[1] = 5'd20;
        cycle();
        chk("read_after_sweep", {16'd0, rd_data[0]}, 32'h0000);
        chk("dropped_write_absent", {16'd0, rd_data[1]}, 32'h0000);

        // Reset aborts a sweep at cycle 12
        fill_index_plus_one();
        clr_req = 1'b1;
        cycle();
        for (int i = 0; i < 12; i++) cycle();
        do_reset();
        read_all();
        clr_req = 1'b1;
        cycle();
        busy_cnt = 0;
        for (int i = 0; i < 36; i++) begin
            if (clr_busy) busy_cnt++;
            cycle();
        end
        chk("sweep_after_reset_length", busy_cnt, 32);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) rand_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
